// File: rtl/serial_match_pkg.sv
// Shared types and constants for the serial pattern-match scheduler.
// Holds the FSM state encoding, the pattern width and the reset pattern.
package serial_match_pkg;

   localparam int PAT_W = 4;
   localparam logic [PAT_W-1:0] DEFAULT_PATTERN = 4'b1101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/pattern_window_detector.sv
// Sliding PAT_W-bit history window with fill counter; hit is combinational in the shift cycle.
// No backpressure: one bit is absorbed whenever shift_en is high; clear wins over shift_en.
module pattern_window_detector
   import serial_match_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             shift_en,
   input  logic             bit_in,
   input  logic             clear,
   input  logic [PAT_W-1:0] pattern,
   output logic             hit
);

   logic [PAT_W-1:0] window_q, window_d;
   logic [PAT_W-1:0] next_window;
   logic [2:0]       fill_q, fill_d;

   // fill_q saturates at PAT_W; a hit needs the incoming bit to complete a full window
   always_comb begin
      next_window = {window_q[PAT_W-2:0], bit_in};
      window_d    = window_q;
      fill_d      = fill_q;
      hit         = 1'b0;
      if (clear) begin
         window_d = '0;
         fill_d   = '0;
      end else if (shift_en) begin
         window_d = next_window;
         if (fill_q != 3'(PAT_W)) begin
            fill_d = fill_q + 3'd1;
         end
         hit = (next_window == pattern) && (fill_q >= 3'(PAT_W - 1));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         window_q <= '0;
         fill_q   <= '0;
      end else begin
         window_q <= window_d;
         fill_q   <= fill_d;
      end
   end

endmodule

// File: rtl/serial_match_scheduler.sv
// Byte-in, bit-serial pattern scanner: 9 cycles per byte, match_pulse/count one cycle after the bit.
// byte_ready is high only in ARMED; the upstream holds byte_valid until it is accepted.
module serial_match_scheduler
   import serial_match_pkg::*;
#(
   parameter int COUNT_W = 8
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         cfg_pattern,
   input  logic               cfg_wr,
   input  logic               start,
   input  logic               byte_valid,
   input  logic [7:0]         byte_data,
   input  logic               byte_last,
   output logic               byte_ready,
   output logic               match_pulse,
   output logic [COUNT_W-1:0] match_count,
   output logic               busy,
   output logic               done
);

   state_e             state_q, state_d;
   logic [PAT_W-1:0]   pattern_q, pattern_d;
   logic [7:0]         data_q, data_d;
   logic               last_q, last_d;
   logic [2:0]         bit_idx_q, bit_idx_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               pulse_q;
   logic               shift_en;
   logic               clear;
   logic               hit;

   pattern_window_detector u_detector (
      .clk      (clk),
      .reset    (reset),
      .shift_en (shift_en),
      .bit_in   (data_q[bit_idx_q]),
      .clear    (clear),
      .pattern  (pattern_q),
      .hit      (hit)
   );

   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      data_d    = data_q;
      last_d    = last_q;
      bit_idx_d = bit_idx_q;
      count_d   = count_q;
      shift_en  = 1'b0;
      clear     = 1'b0;

      // hit only occurs in SHIFT, so the IDLE clear below never races an increment
      if (hit && (count_q != '1)) begin
         count_d = count_q + COUNT_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (cfg_wr) begin
               pattern_d = cfg_pattern;
            end
            if (start) begin
               state_d = ARMED;
               clear   = 1'b1;
               count_d = '0;
            end
         end
         ARMED: begin
            if (byte_valid) begin
               data_d    = byte_data;
               last_d    = byte_last;
               bit_idx_d = 3'd7;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            shift_en  = 1'b1;
            bit_idx_d = bit_idx_q - 3'd1;
            if (bit_idx_q == 3'd0) begin
               state_d = last_q ? DONE : ARMED;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pattern_q <= DEFAULT_PATTERN;
         data_q    <= '0;
         last_q    <= 1'b0;
         bit_idx_q <= '0;
         count_q   <= '0;
         pulse_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         data_q    <= data_d;
         last_q    <= last_d;
         bit_idx_q <= bit_idx_d;
         count_q   <= count_d;
         pulse_q   <= hit;
      end
   end

   assign byte_ready  = (state_q == ARMED);
   assign busy        = (state_q == ARMED) || (state_q == SHIFT);
   assign done        = (state_q == DONE);
   assign match_pulse = pulse_q;
   assign match_count = count_q;

endmodule
